// File: rtl/stream_depth_scaler.sv
// Avalon-ST colour-depth reducer: per-channel truncate/round from IN_BITS to OUT_BITS, registered output plus one-entry skid.
// Optional ordered (2x2 Bayer) dither is enabled with the macro STREAM_DEPTH_SCALER_DITHER_EN.
module stream_depth_scaler #(
    parameter int CHANNELS   = 3,
    parameter int IN_BITS    = 8,
    parameter int OUT_BITS   = 4,
    parameter int ROUND_MODE = 0,
    parameter int LINE_WIDTH = 640
) (
    input  logic                         clock_clk,
    input  logic                         reset,
    input  logic [CHANNELS*IN_BITS-1:0]  data_in,
    input  logic                         sop_in,
    input  logic                         eop_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic [CHANNELS*OUT_BITS-1:0] data_out,
    output logic                         sop_out,
    output logic                         eop_out,
    output logic                         valid_out,
    input  logic                         ready_in
);

    localparam int S  = IN_BITS - OUT_BITS;
    localparam int DW = CHANNELS * OUT_BITS;

    // Handshake: a beat moves on a port in every cycle where its valid and ready are both high;
    // valid never waits on ready, and ready_out is a register equal to "skid not full".
    logic accept;
    logic load;
    assign accept = valid_in && ready_out;
    assign load   = !valid_out || ready_in;

`ifdef STREAM_DEPTH_SCALER_DITHER_EN
    localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

    logic [XW-1:0] x_cnt;
    logic          y_cnt;
    logic [XW-1:0] x_cur;
    logic          y_cur;
    logic [1:0]    bayer;

    // A sop beat sits at the top-left corner itself, so its own position is already cleared.
    assign x_cur = sop_in ? '0 : x_cnt;
    assign y_cur = sop_in ? 1'b0 : y_cnt;

    always_comb begin
        bayer = 2'd0;
        case ({y_cur, x_cur[0]})
            2'b00:   bayer = 2'd0;
            2'b01:   bayer = 2'd2;
            2'b10:   bayer = 2'd3;
            default: bayer = 2'd1;
        endcase
    end

    always_ff @(posedge clock_clk or posedge reset) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= 1'b0;
        end else if (accept) begin
            if (x_cur == XW'(LINE_WIDTH - 1)) begin
                x_cnt <= '0;
                y_cnt <= ~y_cur;
            end else begin
                x_cnt <= x_cur + 1'b1;
                y_cnt <= y_cur;
            end
        end
    end
`endif

    logic [DW-1:0] conv;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [IN_BITS-1:0] ch_in;
        assign ch_in = data_in[c*IN_BITS +: IN_BITS];

        if (S == 0) begin : g_pass
            assign conv[c*OUT_BITS +: OUT_BITS] = ch_in;
        end else begin : g_scale
            logic [IN_BITS:0] offset;
            logic [IN_BITS:0] sum;
`ifdef STREAM_DEPTH_SCALER_DITHER_EN
            if (S >= 2) begin : g_dith
                assign offset = (IN_BITS + 1)'(bayer) << (S - 2);
            end else
`endif
            if (ROUND_MODE == 1) begin : g_rnd
                assign offset = (IN_BITS + 1)'(1) << (S - 1);
            end else begin : g_trn
                assign offset = '0;
            end
            // One spare bit catches the carry out so rounding saturates instead of wrapping.
            assign sum = {1'b0, ch_in} + offset;
            assign conv[c*OUT_BITS +: OUT_BITS] = sum[IN_BITS] ? {OUT_BITS{1'b1}} : sum[IN_BITS-1:S];
        end
    end

    logic          skid_valid;
    logic [DW-1:0] skid_data;
    logic          skid_sop;
    logic          skid_eop;
    logic          skid_valid_nxt;

    // The skid only fills while the output register is held; ready_out is low whenever it is full.
    always_comb begin
        skid_valid_nxt = skid_valid;
        if (load) begin
            skid_valid_nxt = 1'b0;
        end else if (accept) begin
            skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock_clk or posedge reset) begin
        if (reset) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            sop_out    <= 1'b0;
            eop_out    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sop   <= 1'b0;
            skid_eop   <= 1'b0;
            ready_out  <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nxt;
            ready_out  <= !skid_valid_nxt;
            if (load) begin
                if (skid_valid) begin
                    valid_out <= 1'b1;
                    data_out  <= skid_data;
                    sop_out   <= skid_sop;
                    eop_out   <= skid_eop;
                end else if (accept) begin
                    valid_out <= 1'b1;
                    data_out  <= conv;
                    sop_out   <= sop_in;
                    eop_out   <= eop_in;
                end else begin
                    valid_out <= 1'b0;
                end
            end else if (accept) begin
                skid_data <= conv;
                skid_sop  <= sop_in;
                skid_eop  <= eop_in;
            end
        end
    end

endmodule

// File: tb/tb_stream_depth_scaler.sv
// Bench for stream_depth_scaler: truncate, round and pass-through instances share one stimulus stream.
module tb_stream_depth_scaler;

    logic        clk;
    logic        rst;
    logic [23:0] data_in;
    logic        sop_in;
    logic        eop_in;
    logic        valid_in;
    logic        ready_in;

    logic        t_ready, t_sop, t_eop, t_valid;
    logic [11:0] t_data;
    logic        r_ready, r_sop, r_eop, r_valid;
    logic [11:0] r_data;
    logic        p_ready, p_sop, p_eop, p_valid;
    logic [23:0] p_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] exp_q[$];
    logic [23:0] exp_p_q[$];

    stream_depth_scaler #(.ROUND_MODE(0), .LINE_WIDTH(4)) u_trn (
        .clock_clk(clk), .reset(rst), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
        .valid_in(valid_in), .ready_out(t_ready), .data_out(t_data), .sop_out(t_sop),
        .eop_out(t_eop), .valid_out(t_valid), .ready_in(ready_in));

    stream_depth_scaler #(.ROUND_MODE(1), .LINE_WIDTH(4)) u_rnd (
        .clock_clk(clk), .reset(rst), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
        .valid_in(valid_in), .ready_out(r_ready), .data_out(r_data), .sop_out(r_sop),
        .eop_out(r_eop), .valid_out(r_valid), .ready_in(ready_in));

    stream_depth_scaler #(.OUT_BITS(8), .LINE_WIDTH(4)) u_pass (
        .clock_clk(clk), .reset(rst), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
        .valid_in(valid_in), .ready_out(p_ready), .data_out(p_data), .sop_out(p_sop),
        .eop_out(p_eop), .valid_out(p_valid), .ready_in(ready_in));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drives one isolated beat and checks the outputs one clock later.
    task automatic one_beat(input string tag, input logic [23:0] d, input logic [11:0] exp_t,
                            input logic [11:0] exp_r);
        @(negedge clk);
        data_in  = d;
        sop_in   = 1'b1;
        eop_in   = 1'b1;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check({tag, "_valid"}, 32'(t_valid), 32'd1);
        check({tag, "_trn"}, 32'(t_data), 32'(exp_t));
        check({tag, "_rnd"}, 32'(r_data), 32'(exp_r));
        check({tag, "_pass"}, 32'(p_data), 32'(d));
        check({tag, "_sop"}, 32'(t_sop), 32'd1);
        check({tag, "_eop"}, 32'(t_eop), 32'd1);
    endtask

`ifdef STREAM_DEPTH_SCALER_DITHER_EN
    localparam logic [11:0] RND_B = 12'hF00;
`else
    localparam logic [11:0] RND_B = 12'hF11;
`endif

    logic [11:0] prev_data;
    logic        prev_stall;
    int          sent;
    int          rcv;
    logic [7:0]  b;

    initial begin
        rst      = 1'b1;
        data_in  = '0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(t_valid), 32'd0);
        check("rst_ready", 32'(t_ready), 32'd0);
        check("rst_data", 32'(t_data), 32'd0);
        check("rst_sop", 32'(t_sop), 32'd0);
        rst = 1'b0;
        #1 check("rel_ready_before_edge", 32'(t_ready), 32'd0);
        @(negedge clk);
        check("rel_ready", 32'(t_ready), 32'd1);
        check("rel_ready_pass", 32'(p_ready), 32'd1);

        // arithmetic: truncate, round with saturation, round-down boundary
        one_beat("ff8040", 24'hFF8040, 12'hF84, 12'hF84);
        one_beat("f8080f", 24'hF8080F, 12'hF00, RND_B);
        one_beat("070707", 24'h070707, 12'h000, 12'h000);
        @(negedge clk);
        check("idle_valid", 32'(t_valid), 32'd0);

        // backpressure: ready_in low for cycles 3..5, skid full after edges 3..5
        sent = 0;
        rcv = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
            @(negedge clk);
            check("bp_ready", 32'(t_ready), 32'(!(cyc >= 4 && cyc <= 6)));
            if (prev_stall) check("bp_stable", 32'(t_data), 32'(prev_data));
            ready_in = !(cyc >= 3 && cyc <= 5);
            valid_in = (sent < 8);
            b        = {sent[3:0], 4'h0};
            data_in  = {b, b, b};
            sop_in   = (sent == 0);
            eop_in   = (sent == 7);
            if (t_valid && ready_in) begin
                if (exp_q.size() == 0) begin
                    check("bp_unexpected", 32'(t_data), 32'hFFFF_FFFF);
                end else begin
                    check("bp_trn", 32'(t_data), 32'(exp_q[0]));
                    check("bp_rnd", 32'(r_data), 32'(exp_q[0]));
                    check("bp_pass", 32'(p_data), 32'(exp_p_q[0]));
                    void'(exp_q.pop_front());
                    void'(exp_p_q.pop_front());
                end
                rcv++;
            end
            if (valid_in && t_ready) begin
                exp_q.push_back({3{sent[3:0]}});
                exp_p_q.push_back(data_in);
                sent++;
            end
            prev_stall = t_valid && !ready_in;
            prev_data  = t_data;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        check("bp_rcv_count", 32'(rcv), 32'd8);
        check("bp_queue_left", 32'(exp_q.size()), 32'd0);

        // reset mid-packet
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            data_in  = 24'h555555;
            sop_in   = (i == 0);
            eop_in   = 1'b0;
            valid_in = 1'b1;
            @(negedge clk);
        end
        check("mid_valid_before", 32'(t_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_valid_drop", 32'(t_valid), 32'd0);
        check("mid_valid_drop_rnd", 32'(r_valid), 32'd0);
        check("mid_ready_drop", 32'(t_ready), 32'd0);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_idle", 32'(t_valid), 32'd0);
        data_in  = 24'h302010;
        sop_in   = 1'b1;
        eop_in   = 1'b0;
        valid_in = 1'b1;
        @(negedge clk);
        check("new_a_trn", 32'(t_data), 32'h321);
        check("new_a_rnd", 32'(r_data), 32'h321);
        check("new_a_sop", 32'(t_sop), 32'd1);
        check("new_a_eop", 32'(t_eop), 32'd0);
        data_in  = 24'hC0B0A0;
        sop_in   = 1'b0;
        eop_in   = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check("new_b_trn", 32'(t_data), 32'hCBA);
        check("new_b_pass", 32'(p_data), 32'hC0B0A0);
        check("new_b_sop", 32'(t_sop), 32'd0);
        check("new_b_eop", 32'(t_eop), 32'd1);
        @(negedge clk);
        check("new_no_residue", 32'(t_valid), 32'd0);

`ifdef STREAM_DEPTH_SCALER_DITHER_EN
        // 8'h07 with offsets 0,8,0,8 / 12,4,12,4 -> second line alternates 1,0
        begin
            logic [11:0] dith_exp [8];
            dith_exp = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h111, 12'h000, 12'h111, 12'h000};
            for (int i = 0; i < 8; i++) begin
                data_in  = 24'h070707;
                sop_in   = (i == 0);
                eop_in   = (i == 7);
                valid_in = 1'b1;
                @(negedge clk);
                check("dither_trn", 32'(t_data), 32'(dith_exp[i]));
                check("dither_rnd", 32'(r_data), 32'(dith_exp[i]));
            end
            valid_in = 1'b0;
        end
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
